// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared widths, defaults and fetch-entry type
package fetch_queue_pkg;

    localparam int INSTR_LEN = 32;
    localparam int XLEN      = 32;
    localparam int FQ_DEPTH  = 4;
    localparam int FQ_SKID   = 2;

    typedef struct packed {
        logic [INSTR_LEN-1:0] instr;
        logic [XLEN-1:0]      tag;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_ptr.sv
// rtl/fetch_queue_ptr.sv - wrapping queue pointer
module fq_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // DEPTH is a power of two, so natural overflow gives the wrap to 0.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order instruction fetch queue with skid-based stall
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int SKID  = FQ_SKID
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [INSTR_LEN-1:0]       in_instr,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_tag,
    output logic                       fetch_stall,
    output logic [INSTR_LEN-1:0]       out_instr,
    output logic [XLEN-1:0]            out_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_LEVEL  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_LEVEL = CW'(DEPTH - SKID);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          overflow_q;
    logic          overflow_d;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push;
    logic          pop;
    logic          drop;
    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  head;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready && !flush;
    assign push      = in_valid && !flush && ((count_q < FULL_LEVEL) || pop);
    assign drop      = in_valid && !flush && !push;

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q | drop;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately unreset; out_valid alone qualifies the head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= '{instr: in_instr, tag: in_tag};
        end
    end

    fq_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    fq_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    assign head         = mem_q[rd_ptr];
    assign out_instr    = head.instr;
    assign out_tag      = head.tag;
    assign count        = count_q;
    assign fetch_stall  = (count_q >= STALL_LEVEL);
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic                 flush;
    logic [INSTR_LEN-1:0] in_instr;
    logic                 in_valid;
    logic [XLEN-1:0]      in_tag;
    logic                 fetch_stall;
    logic [INSTR_LEN-1:0] out_instr;
    logic [XLEN-1:0]      out_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [2:0]           count;
    logic                 overflow_err;

    int checks = 0;
    int fails  = 0;
    int pops   = 0;
    fetch_entry_t exp_q[$];

    fetch_queue #(.DEPTH(4), .SKID(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_instr     (in_instr),
        .in_valid     (in_valid),
        .in_tag       (in_tag),
        .fetch_stall  (fetch_stall),
        .out_instr    (out_instr),
        .out_tag      (out_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count        (count),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] tag, input bit accept);
        in_valid = v;
        in_instr = instr;
        in_tag   = tag;
        if (accept) exp_q.push_back('{instr: instr, tag: tag});
        cyc();
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: got tag 0x%0h expected no entry", out_tag);
            end else begin
                fetch_entry_t e;
                e = exp_q.pop_front();
                pops++;
                if (out_tag !== e.tag || out_instr !== e.instr) begin
                    fails++;
                    $display("FAIL pop_order: got tag 0x%0h instr 0x%0h expected tag 0x%0h instr 0x%0h",
                             out_tag, out_instr, e.tag, e.instr);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0;
        #7;
        check("reset_count", 32'(count), 0);
        check("reset_valid", 32'(out_valid), 0);
        check("reset_stall", 32'(fetch_stall), 0);
        check("reset_ovf", 32'(overflow_err), 0);
        #5;
        rst_n = 1'b1;

        // two pushes, no pops: stall threshold reached
        drive(1, 32'h0000_0013, 32'h100, 1);
        drive(1, 32'h0010_0093, 32'h104, 1);
        in_valid = 1'b0;
        check("two_count", 32'(count), 2);
        check("two_stall", 32'(fetch_stall), 1);
        check("two_instr", out_instr, 32'h0000_0013);
        check("two_tag", out_tag, 32'h100);

        // fill, then overflow drop
        drive(1, 32'h0020_0113, 32'h108, 1);
        drive(1, 32'h0030_0193, 32'h10c, 1);
        check("full_count", 32'(count), 4);
        check("full_ovf_clear", 32'(overflow_err), 0);
        drive(1, 32'hdead_beef, 32'h200, 0);
        in_valid = 1'b0;
        check("drop_count", 32'(count), 4);
        check("drop_ovf", 32'(overflow_err), 1);
        check("drop_head", out_tag, 32'h100);

        // push and pop together while full
        out_ready = 1'b1;
        drive(1, 32'h0000_02b7, 32'h200, 1);
        in_valid = 1'b0;
        check("full_pushpop_count", 32'(count), 4);
        repeat (4) cyc();
        check("drained_count", 32'(count), 0);
        check("drained_valid", 32'(out_valid), 0);
        check("drained_pops", pops, 5);

        // flush with a simultaneous push
        out_ready = 1'b0;
        drive(1, 32'h0000_0300, 32'h300, 1);
        drive(1, 32'h0000_0304, 32'h304, 1);
        drive(1, 32'h0000_0308, 32'h308, 1);
        check("pre_flush_count", 32'(count), 3);
        exp_q.delete();
        flush = 1'b1;
        drive(1, 32'h0000_030c, 32'h30c, 0);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_count", 32'(count), 0);
        check("flush_valid", 32'(out_valid), 0);
        check("flush_stall", 32'(fetch_stall), 0);
        check("flush_ovf_sticky", 32'(overflow_err), 1);

        // async reset between edges at count=2
        drive(1, 32'h0000_0400, 32'h400, 1);
        drive(1, 32'h0000_0404, 32'h404, 1);
        in_valid = 1'b0;
        check("pre_rst_head", out_tag, 32'h400);
        check("pre_rst_count", 32'(count), 2);
        #2;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 0);
        check("arst_count", 32'(count), 0);
        check("arst_stall", 32'(fetch_stall), 0);
        check("arst_ovf", 32'(overflow_err), 0);
        #3;
        rst_n = 1'b1;
        cyc();

        // streaming: both pointers wrap twice
        pops = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h0000_1000 + 32'(i), 32'(i * 4), 1);
        end
        in_valid = 1'b0;
        repeat (3) cyc();
        check("stream_pops", pops, 10);
        check("stream_left", exp_q.size(), 0);
        check("stream_count", 32'(count), 0);
        check("stream_ovf", 32'(overflow_err), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of queue entries; power of two, minimum 4.
REQ-002 Parameter: SKID, default 2, entries kept free for responses already in flight when the stall asserts; range 1 to DEPTH-1.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: flush  input  1  discards all queued entries (redirect).
REQ-006 Port: in_instr  input  INSTR_LEN  instruction word from the fetch stage.
REQ-007 Port: in_valid  input  1  in_instr and in_tag are valid this cycle.
REQ-008 Port: in_tag  input  XLEN  PC of in_instr.
REQ-009 Port: fetch_stall  output  1  throttles the fetch stage; drives its pipe_stall.
REQ-010 Port: out_instr  output  INSTR_LEN  head-entry instruction to decode.
REQ-011 Port: out_tag  output  XLEN  head-entry PC.
REQ-012 Port: out_valid  output  1  head entry present.
REQ-013 Port: out_ready  input  1  decode accepts the head entry this cycle.
REQ-014 Port: count  output  $clog2(DEPTH+1)  current number of occupied entries.
REQ-015 Port: overflow_err  output  1  sticky flag; an input was dropped.

Function
REQ-016 Push occurs when in_valid=1 and either count<DEPTH or a pop happens in the same cycle; flush=1 blocks the push.
REQ-017 Pop occurs when out_valid=1 and out_ready=1; flush=1 blocks the pop.
REQ-018 Storage is in-order FIFO: entries leave in arrival order.
REQ-019 out_valid = (count!=0); out_instr and out_tag are driven combinationally from the head entry with zero added latency.
REQ-020 Read and write pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0 without a gap.
REQ-021 A simultaneous push and pop leaves count unchanged and is legal at count=DEPTH.
REQ-022 A simultaneous push and pop at count=0 is impossible, because out_valid=0; the entry is enqueued and appears on out_valid in the next cycle, so the queue has no bypass.
REQ-023 count increments on push-only, decrements on pop-only, and never exceeds DEPTH or goes below 0.
REQ-024 fetch_stall = (count >= DEPTH-SKID); it is driven combinationally from the registered count.
REQ-025 When in_valid=1, count=DEPTH, there is no pop and no flush, the entry is dropped, the queue state is unchanged, and overflow_err is set to 1 on the next edge.
REQ-026 overflow_err remains 1 until reset; flush does not clear it.
REQ-027 On flush=1, the next edge sets count=0 and both pointers to 0, and inputs that cycle are ignored; out_valid=0 and fetch_stall=0 hold from the following cycle.
REQ-028 out_instr and out_tag are don't-care while out_valid=0; they are never X-propagating into out_valid.

Reset
REQ-029 Asserting rst_n=0 at any time, including mid-transfer, immediately sets count=0, both pointers to 0, out_valid=0, fetch_stall=0 and overflow_err=0.
REQ-030 Entry storage is not reset.
REQ-031 The first push is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-032 The fetch-entry packed struct (instr INSTR_LEN, tag XLEN) is a typedef in the shared global package, reusing the package's INSTR_LEN and XLEN.
REQ-033 The default DEPTH and SKID are constants in the shared package.
REQ-034 A single sub-module, fq_ptr, implements the wrapping pointer; it is instantiated twice, once for read and once for write.
REQ-035 All other logic is local to fetch_queue.

Verification (DEPTH=4, SKID=2)
REQ-036 Push 0x00000013 @tag 0x100, then 0x00100093 @tag 0x104, with out_ready=0 -> count=2, fetch_stall=1, out_instr=0x00000013, out_tag=0x100.
REQ-037 Fill the queue to 4 entries, then in_valid=1 with tag 0x200 and out_ready=0 -> entry dropped, count=4, overflow_err=1 next cycle and remains 1 after a flush.
REQ-038 At count=4, apply in_valid=1 and out_ready=1 together -> count stays 4; pop order is the old head first and tag 0x200 last.
REQ-039 Stream 10 sequential tags 0x0 to 0x24 with out_ready=1 continuously -> every tag emerges once in order after both pointers wrap twice, with no overflow.
REQ-040 At count=3, apply flush=1 together with in_valid=1 -> next cycle count=0, out_valid=0, fetch_stall=0, and the flushed-cycle entry never appears.
REQ-041 Drive rst_n=0 mid-stream between clock edges at count=2 -> out_valid, count, fetch_stall and overflow_err go to 0 immediately, without waiting for clk.
